// File: rtl/axi3_cmd_arbiter.sv
// Two-requester round-robin front end for a single AXI3 master command port.
// Holds the grant until BRESP or the last R beat, with a watchdog abort for hung bursts.
module axi3_cmd_arbiter #(
  parameter int DATAWIDTH = 32,
  parameter int SIZE      = 3,
  parameter int TIMEOUT   = 256
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [1:0]                   req,
  input  logic [1:0]                   req_write,
  input  logic [2*DATAWIDTH-1:0]       req_addr,
  input  logic [2*(DATAWIDTH/8)-1:0]   req_len,
  input  logic [2*SIZE-1:0]            req_size,
  input  logic [2*(SIZE-1)-1:0]        req_burst,
  input  logic [2*(DATAWIDTH/8)-1:0]   req_id,
  input  logic [2*DATAWIDTH-1:0]       req_wdata,
  input  logic [2*(DATAWIDTH/8)-1:0]   req_wstrb,
  output logic [1:0]                   gnt,
  output logic [1:0]                   done,
  output logic [1:0]                   err,
  output logic [1:0]                   resp,
  output logic [DATAWIDTH-1:0]         AWaddr,
  output logic [DATAWIDTH/8-1:0]       AWlen,
  output logic [DATAWIDTH/8-1:0]       AWid,
  output logic [SIZE-1:0]              AWsize,
  output logic [SIZE-2:0]              AWburst,
  output logic [DATAWIDTH-1:0]         WData,
  output logic [DATAWIDTH/8-1:0]       WStrb,
  output logic [DATAWIDTH-1:0]         ARaddr,
  output logic [DATAWIDTH/8-1:0]       ARlen,
  output logic [DATAWIDTH/8-1:0]       ARid,
  output logic [SIZE-1:0]              ARsize,
  output logic [SIZE-2:0]              ARburst,
  output logic                         wr_start,
  output logic                         rd_start,
  input  logic                         BVALID,
  input  logic                         BREADY,
  input  logic [1:0]                   BRESP,
  input  logic                         RVALID,
  input  logic                         RREADY,
  input  logic                         RLAST
);

  localparam int LW  = DATAWIDTH / 8;
  localparam int BW  = SIZE - 1;
  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e                state_q;
  logic                  rr_last_q, own_q, wr_q;
  logic [WDW-1:0]        wdog_q;
  logic [1:0]            gnt_q, done_q, err_q, resp_q;
  logic                  wr_start_q, rd_start_q;
  logic [DATAWIDTH-1:0]  awaddr_q, araddr_q, wdata_q;
  logic [LW-1:0]         awlen_q, awid_q, arlen_q, arid_q, wstrb_q;
  logic [SIZE-1:0]       awsize_q, arsize_q;
  logic [BW-1:0]         awburst_q, arburst_q;

  logic                  win_d, wr_d, cmp_d;
  logic [DATAWIDTH-1:0]  addr_d, wdata_d;
  logic [LW-1:0]         len_d, id_d, wstrb_d;
  logic [SIZE-1:0]       size_d;
  logic [BW-1:0]         burst_d;

  // On a tie the requester that was not served last wins.
  always_comb begin
    win_d   = (req == 2'b11) ? ~rr_last_q : req[1];
    wr_d    = req_write[win_d];
    addr_d  = win_d ? req_addr[2*DATAWIDTH-1:DATAWIDTH]  : req_addr[DATAWIDTH-1:0];
    wdata_d = win_d ? req_wdata[2*DATAWIDTH-1:DATAWIDTH] : req_wdata[DATAWIDTH-1:0];
    len_d   = win_d ? req_len[2*LW-1:LW]     : req_len[LW-1:0];
    id_d    = win_d ? req_id[2*LW-1:LW]      : req_id[LW-1:0];
    wstrb_d = win_d ? req_wstrb[2*LW-1:LW]   : req_wstrb[LW-1:0];
    size_d  = win_d ? req_size[2*SIZE-1:SIZE] : req_size[SIZE-1:0];
    burst_d = win_d ? req_burst[2*BW-1:BW]   : req_burst[BW-1:0];
    cmp_d   = wr_q ? (BVALID & BREADY) : (RVALID & RREADY & RLAST);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rr_last_q  <= 1'b1;
      own_q      <= 1'b0;
      wr_q       <= 1'b0;
      wdog_q     <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
      resp_q     <= '0;
      wr_start_q <= 1'b0;
      rd_start_q <= 1'b0;
      awaddr_q   <= '0;
      awlen_q    <= '0;
      awid_q     <= '0;
      awsize_q   <= '0;
      awburst_q  <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arid_q     <= '0;
      arsize_q   <= '0;
      arburst_q  <= '0;
    end else begin
      done_q     <= '0;
      err_q      <= '0;
      wr_start_q <= 1'b0;
      rd_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            own_q   <= win_d;
            wr_q    <= wr_d;
            gnt_q   <= win_d ? 2'b10 : 2'b01;
            state_q <= S_ISSUE;
            // Only the channel being launched is reloaded; the other keeps its last command.
            if (wr_d) begin
              awaddr_q   <= addr_d;
              awlen_q    <= len_d;
              awid_q     <= id_d;
              awsize_q   <= size_d;
              awburst_q  <= burst_d;
              wdata_q    <= wdata_d;
              wstrb_q    <= wstrb_d;
              wr_start_q <= 1'b1;
            end else begin
              araddr_q   <= addr_d;
              arlen_q    <= len_d;
              arid_q     <= id_d;
              arsize_q   <= size_d;
              arburst_q  <= burst_d;
              rd_start_q <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          wdog_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A completion seen on the watchdog's last cycle still counts as success.
          if (cmp_d) begin
            done_q    <= own_q ? 2'b10 : 2'b01;
            resp_q    <= wr_q ? BRESP : 2'b00;
            gnt_q     <= '0;
            rr_last_q <= own_q;
            state_q   <= S_IDLE;
          end else if (wdog_q == WD_LAST) begin
            err_q     <= own_q ? 2'b10 : 2'b01;
            resp_q    <= 2'b10;
            gnt_q     <= '0;
            rr_last_q <= own_q;
            state_q   <= S_IDLE;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign err      = err_q;
  assign resp     = resp_q;
  assign wr_start = wr_start_q;
  assign rd_start = rd_start_q;
  assign AWaddr   = awaddr_q;
  assign AWlen    = awlen_q;
  assign AWid     = awid_q;
  assign AWsize   = awsize_q;
  assign AWburst  = awburst_q;
  assign WData    = wdata_q;
  assign WStrb    = wstrb_q;
  assign ARaddr   = araddr_q;
  assign ARlen    = arlen_q;
  assign ARid     = arid_q;
  assign ARsize   = arsize_q;
  assign ARburst  = arburst_q;

endmodule

// File: doc/axi3_cmd_arbiter.md
Name: axi3_cmd_arbiter

Overview:
- Shares the single AXI3 master command port between two requesters (testbench agents or on-chip clients).
- Arbitrates round-robin, registers the winner's command onto the master's AW/W/AR inputs and pulses a start strobe.
- Holds the grant until the AXI write response or the last read beat completes on the interface.
- A watchdog timeout releases hung transactions so the other requester is never starved.

Parameters:
- DATAWIDTH, 32, address/data width; len/id/strb width is DATAWIDTH/8.
- SIZE, 3, size field width; burst width is SIZE-1.
- TIMEOUT, 256, maximum cycles in WAIT before abort (≥2).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  2  per-requester request; held high until done/err.
- req_write  in  2  1 = write, 0 = read.
- req_addr  in  2*DATAWIDTH  requester i at [i*DATAWIDTH +: DATAWIDTH].
- req_len  in  2*(DATAWIDTH/8)  burst length minus one, packed likewise.
- req_size  in  2*SIZE  beat size.
- req_burst  in  2*(SIZE-1)  burst type.
- req_id  in  2*(DATAWIDTH/8)  transaction ID.
- req_wdata  in  2*DATAWIDTH  write data.
- req_wstrb  in  2*(DATAWIDTH/8)  write strobes.
- gnt  out  2  one-hot grant, high from ISSUE through completion.
- done  out  2  one-cycle completion pulse to the granted requester.
- err  out  2  one-cycle timeout pulse to the granted requester.
- resp  out  2  response: BRESP for writes, 2'b00 for reads, 2'b10 on timeout; valid with done/err, held until next completion.
- AWaddr, ARaddr  out  DATAWIDTH each  to master.
- AWlen, AWid, ARlen, ARid, WStrb  out  DATAWIDTH/8 each  to master.
- AWsize, ARsize  out  SIZE each  to master.
- AWburst, ARburst  out  SIZE-1 each  to master.
- WData  out  DATAWIDTH  to master.
- wr_start  out  1  one-cycle strobe: launch write on master.
- rd_start  out  1  one-cycle strobe: launch read on master.
- BVALID, BREADY, RVALID, RREADY, RLAST  in  1 each  monitored from the AXI interface.
- BRESP  in  2  monitored write response.

Behaviour:
- Reset (asynchronous, reset low):
  - All outputs 0; state IDLE; watchdog 0.
  - rr_last = 1, so requester 0 wins first.
  - Reset asserted mid-transaction aborts silently: no done/err pulse.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req bit is high, the winner is the requester not equal to rr_last when both are high, otherwise the single requester.
  - At the clock edge:
    - Register the winner's fields.
    - Write: drives AW*/W* outputs only. Read: drives AR* outputs only. Channel outputs not loaded hold their previous values.
    - Set gnt[winner] and go to ISSUE.
- ISSUE (exactly 1 cycle):
  - wr_start = 1 if write, otherwise rd_start = 1.
  - Clear watchdog; go to WAIT.
- WAIT:
  - Write completes on BVALID & BREADY; resp <= BRESP.
  - Read completes on RVALID & RREADY & RLAST; resp <= 2'b00.
  - Non-last read beats are ignored.
  - Completion edge: done[winner] pulses next cycle, gnt clears, rr_last <= winner, go to IDLE.
  - Watchdog increments each WAIT cycle. When it reaches TIMEOUT-1 without completion: err[winner] pulses, resp <= 2'b10, gnt clears, rr_last <= winner, go to IDLE.
  - Completion and timeout in the same cycle: completion wins, no err.
- Latency:
  - req sampled in IDLE at cycle N; gnt and start strobe high in cycle N+1.
  - Minimum gnt-to-gnt spacing is 1 idle cycle after done.
- req deassertion while granted is ignored; the transaction runs to completion.
- Back-to-back requests from the same requester are served alternately when the other requester is also requesting.
- wr_start and rd_start are never high simultaneously.
- gnt is always one-hot or zero.

Test Plan:
- Reset, then req=2'b01 write, addr=0x0000_0010, len=3, size=2, burst=1, id=5, wdata=0xDEADBEEF, wstrb=0xF → gnt=01 and wr_start one cycle later with AWaddr=0x10, AWlen=3; BVALID&BREADY with BRESP=0 → done=01 for one cycle, resp=00.
- req=2'b11 both reads held continuously → grants alternate 01, 10, 01; rd_start observed with ARaddr matching each requester.
- Read len=3: three beats with RLAST=0 → no done; fourth beat with RLAST=1 → done pulse the next cycle.
- TIMEOUT=8, write granted, BVALID never asserted → err pulses after the watchdog reaches 7; resp=10; gnt clears; the pending other requester is granted next.
- Completion on the same cycle as the watchdog limit → done only, no err.
- Reset deasserted-then-asserted low during WAIT → all outputs 0 immediately, no done/err; after release, requester 0 wins the first tie.
